// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode instruction buffer.
// Small FIFO of PC/instruction pairs with valid/ready on both sides.
module if_id_queue #(
  parameter int DEPTH = 2
) (
  input  logic                     reloj,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_pc,
  input  logic [31:0]              fetch_instr,
  output logic                     fetch_ready,
  input  logic                     flush,
  input  logic                     dec_ready,
  output logic                     dec_valid,
  output logic [31:0]              dec_pc,
  output logic [31:0]              dec_instr,
  output logic [31:0]              dec_pc_plus4,
  output logic [3:0]               dec_pc_hi,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push;
  logic          pop;

  assign fetch_ready = (cnt_q != FULL);
  assign dec_valid   = (cnt_q != '0);
  assign push        = fetch_valid & fetch_ready;
  assign pop         = dec_valid & dec_ready;

  // Next pointers and count; flush drops everything in flight.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      unique case (1'b1)
        (push && !pop): cnt_d = cnt_q + CW'(1);
        (pop && !push): cnt_d = cnt_q - CW'(1);
        default:        cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge reloj) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are masked at the outputs when empty.
  always_ff @(posedge reloj) begin
    if (reset && !flush && push) begin
      pc_q[wr_q]    <= fetch_pc;
      instr_q[wr_q] <= fetch_instr;
    end
  end

  assign dec_pc       = dec_valid ? pc_q[rd_q] : 32'h0;
  assign dec_instr    = dec_valid ? instr_q[rd_q] : 32'h0;
  assign dec_pc_plus4 = dec_pc + 32'd4;
  assign dec_pc_hi    = dec_pc[31:28];
  assign occupancy    = cnt_q;

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction buffer between the fetch stage and decode. It captures each fetched PC/instruction pair into a small FIFO and presents the oldest entry to decode, together with PC+4 and PC[31:28] for jump-target formation. It decouples decode stalls from the PC register using a valid/ready handshake on both sides, and discards all buffered work on a control-flow flush.

## Interface

Parameters:
- DEPTH, 2, number of entries; power of two, 2 or 4.

Ports:
- reloj  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-low; 0 at a rising edge resets the block.
- fetch_valid  in  1  fetch presents a valid PC/instruction pair.
- fetch_pc  in  32  PC of the presented instruction.
- fetch_instr  in  32  instruction word read at fetch_pc.
- fetch_ready  out  1  queue accepts a pair this cycle.
- flush  in  1  discard all entries (branch, jump, JR, or SEL_DIR≠00 redirect).
- dec_ready  in  1  decode consumes the head entry this cycle.
- dec_valid  out  1  head entry is valid.
- dec_pc  out  32  PC of the head entry.
- dec_instr  out  32  instruction of the head entry; 32'h0000_0000 (NOP) when dec_valid=0.
- dec_pc_plus4  out  32  dec_pc + 4, modulo 2^32.
- dec_pc_hi  out  4  dec_pc[31:28].
- occupancy  out  log2(DEPTH)+1  number of valid entries.

## Operation

- Storage: DEPTH entries, each holding a 32-bit PC and a 32-bit instruction.
- Pointers: a write pointer and a read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH. A count register ranges 0..DEPTH.
- push = fetch_valid & fetch_ready.
- pop = dec_valid & dec_ready.
- fetch_ready = (count != DEPTH). It depends on count only, never on dec_ready. A full queue therefore refuses a push even in a cycle where it pops.
- dec_valid = (count != 0).
- dec_pc and dec_instr come from the entry at the read pointer. When count = 0, dec_pc = 0 and dec_instr = 0 (forced).
- dec_pc_plus4 and dec_pc_hi are derived combinationally from dec_pc. The +4 wraps: 32'hFFFF_FFFC gives 32'h0000_0000.
- occupancy = count.
- Update priority, evaluated at each rising edge:
  1. reset = 0: count, write pointer and read pointer become 0. Storage contents are don't-care but must never reach the outputs.
  2. flush = 1: count and both pointers become 0. A push or pop in the same cycle is ignored, and the fetch pair presented that cycle is discarded.
  3. push and pop together: write at the write pointer, advance both pointers, count unchanged.
  4. push only: write the entry, advance the write pointer, count + 1.
  5. pop only: advance the read pointer, count − 1.
  6. Neither: hold all state.
- Entries leave in push order (FIFO). No entry is duplicated or dropped except by flush or reset.

## Timing

- Reset values (visible the cycle after reset is sampled low):
  - dec_valid = 0, dec_pc = 0, dec_instr = 0.
  - dec_pc_plus4 = 32'h0000_0004, dec_pc_hi = 0.
  - fetch_ready = 1, occupancy = 0.
- Latency: a pair pushed at edge N appears on the dec_* outputs in cycle N+1 if the queue was empty. There is no combinational fetch-to-decode bypass.
- Throughput: with DEPTH ≥ 2, continuous push and pop sustain one instruction per cycle.
- Full: with count = DEPTH, fetch_ready = 0. The fetch stage must hold its PC; the upstream PC advance is gated by fetch_ready. A pop at edge N makes fetch_ready = 1 in cycle N+1.
- Empty: dec_valid = 0 and a NOP is presented. dec_ready is ignored.
- Flush: outputs read empty in the cycle after the flush edge. The first post-flush push can be popped one cycle after it is pushed.
- Reset mid-stream: identical to flush, and it overrides flush.
- All outputs are functions of registered state only; there are no combinational in-to-out paths.

## Test plan

- Reset: hold reset=0 for 2 cycles with fetch_valid=1 → occupancy=0, dec_valid=0, dec_instr=0, dec_pc_plus4=4, fetch_ready=1.
- Streaming: with dec_ready=1, push PCs 0, 4, 8, 12 with instructions 0x20080001..0x20080004 on consecutive cycles → decode sees them in order one cycle later, occupancy stays at 1, no bubbles.
- Fill and stall: DEPTH=2, dec_ready=0, push PCs 0x100 and 0x104 → occupancy=2 and fetch_ready=0. A third pair at 0x108 is not accepted. Raising dec_ready pops 0x100, then fetch_ready returns to 1 in the next cycle.
- Flush priority: queue holds 2 entries, then assert flush together with fetch_valid (PC 0x200) and dec_ready → next cycle occupancy=0, dec_valid=0, and 0x200 is not stored.
- Wrap: dec_pc = 0xFFFF_FFFC → dec_pc_plus4 = 0, dec_pc_hi = 4'hF. Run 10 push/pop cycles so both pointers wrap several times → order preserved.
- Reset over flush: reset=0 and flush=1 with a full queue → reset values exactly as listed in the reset scenario.
